// File: rtl/grad_bram_sequencer.sv
// grad_bram_sequencer: plays back 4-word gradient samples from BRAM at a fixed cadence into the SPI stage.
// Optional macro GRAD_SEQ_LOOP_EN adds loop_i for endless playback until stop_i.
module grad_bram_sequencer #(
    parameter int ADDR_W       = 13,
    parameter int INTERVAL_W   = 16,
    parameter int MIN_INTERVAL = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_W-3:0]     n_samples_i,
    input  logic [INTERVAL_W-1:0] interval_i,
`ifdef GRAD_SEQ_LOOP_EN
    input  logic                  loop_i,
`endif
    output logic                  bram_en_o,
    output logic [ADDR_W-1:0]     bram_addr_o,
    input  logic [31:0]           bram_rdata_i,
    output logic [23:0]           datax_o,
    output logic [23:0]           datay_o,
    output logic [23:0]           dataz_o,
    output logic [23:0]           dataz2_o,
    output logic                  valid_o,
    input  logic                  busy_i,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  underrun_o,
    output logic [ADDR_W-3:0]     sample_idx_o
);

    localparam int SW = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_TICK, WAIT_READY, EMIT} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         n_q, n_d, k_q, k_d, idx_q, idx_d;
    logic [INTERVAL_W-1:0] ival_q, ival_d, tick_q, tick_d;
    logic [2:0]            fcnt_q, fcnt_d;
    logic [1:0]            guard_q, guard_d;
    logic [3:0][23:0]      sh_q, sh_d, data_q, data_d;
    logic                  first_q, first_d, loop_q, loop_d, in_ready_q, in_ready_d;
    logic                  valid_q, valid_d, done_q, done_d;
    logic                  running_q, running_d, underrun_q, underrun_d;
    logic                  last, go, unused_hi;

    assign unused_hi    = ^bram_rdata_i[31:24];
    assign last         = k_q == n_q - SW'(1);
    assign go           = !busy_i && guard_q == '0 && !stop_i;
    assign bram_en_o    = state_q == FETCH && fcnt_q != 3'd4;
    assign bram_addr_o  = bram_en_o ? {k_q, fcnt_q[1:0]} : '0;
    assign datax_o      = data_q[0];
    assign datay_o      = data_q[1];
    assign dataz_o      = data_q[2];
    assign dataz2_o     = data_q[3];
    assign valid_o      = valid_q;
    assign done_o       = done_q;
    assign running_o    = running_q;
    assign underrun_o   = underrun_q;
    assign sample_idx_o = idx_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        idx_d      = idx_q;
        ival_d     = ival_q;
        fcnt_d     = fcnt_q;
        sh_d       = sh_q;
        data_d     = data_q;
        first_d    = first_q;
        loop_d     = loop_q;
        running_d  = running_q;
        underrun_d = underrun_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        tick_d     = tick_q != '0 ? tick_q - INTERVAL_W'(1) : '0;
        guard_d    = guard_q != '0 ? guard_q - 2'd1 : '0;
        in_ready_d = state_q == WAIT_READY;
        case (state_q)
            IDLE: if (start_i && !stop_i) begin
                n_d        = n_samples_i;
                ival_d     = interval_i < INTERVAL_W'(MIN_INTERVAL) ? INTERVAL_W'(MIN_INTERVAL) : interval_i;
`ifdef GRAD_SEQ_LOOP_EN
                loop_d     = loop_i;
`else
                loop_d     = 1'b0;
`endif
                underrun_d = 1'b0;
                k_d        = '0;
                fcnt_d     = '0;
                first_d    = 1'b1;
                if (n_samples_i == '0) done_d = 1'b1;
                else begin
                    running_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                fcnt_d = fcnt_q + 3'd1;
                // read data trails the enable by one cycle, so slot fcnt-1 lands now
                if (fcnt_q != '0) sh_d[fcnt_q[1:0] - 2'd1] = bram_rdata_i[23:0];
                if (fcnt_q == 3'd4) state_d = WAIT_TICK;
            end
            // the remaining two cycles of the interval are spent in WAIT_READY and EMIT
            WAIT_TICK: if (first_q || tick_q <= INTERVAL_W'(2)) state_d = WAIT_READY;
            WAIT_READY: begin
                if (!in_ready_q && busy_i && guard_q == '0 && !stop_i) underrun_d = 1'b1;
                if (go) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    data_d  = sh_q;
                    idx_d   = k_q;
                    done_d  = last && !loop_q;
                end
            end
            EMIT: begin
                tick_d  = ival_q - INTERVAL_W'(1);
                guard_d = 2'd2;
                first_d = 1'b0;
                fcnt_d  = '0;
                k_d     = last ? '0 : k_q + SW'(1);
                if (last && !loop_q) begin
                    state_d   = IDLE;
                    running_d = 1'b0;
                end else state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (stop_i && state_q != IDLE) begin
            state_d   = IDLE;
            running_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            ival_q     <= '0;
            tick_q     <= '0;
            fcnt_q     <= '0;
            guard_q    <= '0;
            sh_q       <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            loop_q     <= 1'b0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            ival_q     <= ival_d;
            tick_q     <= tick_d;
            fcnt_q     <= fcnt_d;
            guard_q    <= guard_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            first_q    <= first_d;
            loop_q     <= loop_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            running_q  <= running_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_grad_bram_sequencer.sv
// tb_grad_bram_sequencer: randomized playback runs scored against a timing-level model of the sequencer.
module tb_grad_bram_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, stop_i = 1'b0, busy_i = 1'b0;
    logic [10:0] n_samples_i = '0;
    logic [15:0] interval_i = '0;
`ifdef GRAD_SEQ_LOOP_EN
    logic        loop_i = 1'b0;
`endif
    logic        bram_en_o;
    logic [12:0] bram_addr_o;
    logic [31:0] bram_rdata_i = '0;
    logic [23:0] datax_o, datay_o, dataz_o, dataz2_o;
    logic        valid_o, running_o, done_o, underrun_o;
    logic [10:0] sample_idx_o;

    grad_bram_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .n_samples_i(n_samples_i), .interval_i(interval_i),
`ifdef GRAD_SEQ_LOOP_EN
        .loop_i(loop_i),
`endif
        .bram_en_o(bram_en_o), .bram_addr_o(bram_addr_o), .bram_rdata_i(bram_rdata_i),
        .datax_o(datax_o), .datay_o(datay_o), .dataz_o(dataz_o), .dataz2_o(dataz2_o),
        .valid_o(valid_o), .busy_i(busy_i), .running_o(running_o), .done_o(done_o),
        .underrun_o(underrun_o), .sample_idx_o(sample_idx_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [8192];
    always @(posedge clk) if (bram_en_o) bram_rdata_i <= mem[bram_addr_o];

    int total = 0, bad = 0;
    int t = 0, m_n = 0, m_ival = 8, m_k = 0, m_ready = 0, m_end = -1;
    int lastv = 0, vcnt = 0, stop_v = 0, stop_d = 0, g_n = 0, g_iv = 0;
    int obs_v = 0, gap = 0, ndone = 0, d0 = 0;
    bit m_run = 0, m_loop = 0, have_v = 0, g_lp = 0, found = 0;
    logic        e_valid = 0, e_done = 0, e_run = 0, e_urun = 0;
    logic [95:0] e_data = '0;
    logic [10:0] e_idx = '0;
    logic [47:0] s1 = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic step(input bit st, input int md);
        @(posedge clk); #1; t++;
        check("valid", valid_o, e_valid);
        check("done", done_o, e_done);
        check("running", running_o, e_run);
        check("underrun", underrun_o, e_urun);
        check("data", {datax_o, datay_o, dataz_o, dataz2_o}, e_data);
        check("idx", sample_idx_o, e_idx);
        if (bram_en_o) check("addr_rng", int'(bram_addr_o) < 4 * m_n, 1);
        if (valid_o) begin
            gap = t - obs_v;
            obs_v = t;
            if (sample_idx_o == 11'd1) s1 = {datax_o, dataz2_o};
        end
        if (done_o) ndone++;
        busy_i  = md == 1 ? (have_v && t >= lastv + 2 && t <= lastv + 31) :
                  md == 2 ? ($urandom_range(3) == 0) : 1'b0;
        stop_i  = stop_v > 0 && vcnt == stop_v && t == lastv + stop_d;
        start_i = st;
        e_valid = 0;
        e_done  = 0;
        if (m_run) begin
            if (t == m_end || stop_i) begin
                m_run = 0;
                e_run = 0;
            end else begin
                if (t == m_ready && busy_i) e_urun = 1;
                if (t >= m_ready && !busy_i) begin
                    e_valid = 1;
                    e_idx   = 11'(m_k);
                    e_data  = {mem[4*m_k][23:0], mem[4*m_k+1][23:0], mem[4*m_k+2][23:0], mem[4*m_k+3][23:0]};
                    m_ready = t + m_ival;
                    vcnt++;
                    lastv  = t + 1;
                    have_v = 1;
                    if (m_k == m_n - 1) begin
                        if (m_loop) m_k = 0;
                        else begin
                            e_done = 1;
                            m_end  = t + 1;
                        end
                    end else m_k++;
                end
            end
        end else if (st && !stop_i) begin
            m_n    = g_n;
            m_ival = g_iv < 8 ? 8 : g_iv;
            m_loop = g_lp;
            e_urun = 0;
            if (g_n == 0) e_done = 1;
            else begin
                m_run   = 1;
                e_run   = 1;
                m_k     = 0;
                m_ready = t + 7;
                m_end   = -1;
            end
        end
    endtask

    task automatic run(input int ns, input int iv, input int md, input bit lp, input int sv, input int sd, input int ncyc);
        n_samples_i = 11'(ns);
        interval_i  = 16'(iv);
`ifdef GRAD_SEQ_LOOP_EN
        loop_i = lp;
`endif
        g_n = ns; g_iv = iv; g_lp = lp;
        stop_v = sv; stop_d = sd; vcnt = 0; have_v = 0;
        for (int i = 0; i < ncyc; i++) step(i == 0, md);
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = $urandom;
        for (int a = 0; a < 12; a++) mem[a] = 32'h00A000 + a;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {bram_en_o, bram_addr_o, datax_o, datay_o, dataz_o, dataz2_o,
                        valid_o, running_o, done_o, underrun_o, sample_idx_o}, '0);
        rst = 1'b0;

        s1 = '0;
        run(3, 20, 0, 0, 0, 0, 80);
        check("basic_gap", gap, 20);
        check("basic_s1", s1, {24'h00A004, 24'h00A007});
        check("basic_run", running_o, 0);

        run(3, 3, 0, 0, 0, 0, 60);
        check("floor_gap", gap, 8);

        run(3, 10, 1, 0, 0, 0, 150);
        check("urun_flag", underrun_o, 1);
        check("urun_gap", gap, 33);

        d0 = ndone;
        run(10, 12, 0, 0, 2, 3, 120);
        check("stop_idx", sample_idx_o, 1);
        check("stop_run", running_o, 0);
        check("stop_nodone", ndone - d0, 0);

        n_samples_i = 11'd3; interval_i = 16'd10; g_n = 3; g_iv = 10; g_lp = 0; stop_v = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(i == 0, 0);
            found = bram_en_o;
        end
        check("fetch_seen", found, 1);
        rst = 1'b1;
        #1;
        check("rst_async", {bram_en_o, bram_addr_o, datax_o, datay_o, dataz_o, dataz2_o,
                            valid_o, running_o, done_o, underrun_o, sample_idx_o}, '0);
        @(posedge clk); #1; t++;
        rst = 1'b0; start_i = 1'b0;
        m_run = 0; e_valid = 0; e_done = 0; e_run = 0; e_urun = 0; e_data = '0; e_idx = '0;
        d0 = ndone;
        run(1, 9, 0, 0, 0, 0, 30);
        check("rst_restart_done", ndone - d0, 1);

`ifdef GRAD_SEQ_LOOP_EN
        d0 = ndone;
        run(2, 12, 0, 1, 5, 1, 100);
        check("loop_gap", gap, 12);
        check("loop_nodone", ndone - d0, 0);
        check("loop_run", running_o, 0);
`endif

        for (int r = 0; r < 12; r++) begin
            int ns, iv, ivf, md, sv, sd;
            bit lp;
            ns = $urandom_range(0, 5);
            iv = $urandom_range(0, 30);
            md = $urandom_range(0, 2);
            sv = $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0;
            sd = $urandom_range(0, 12);
            lp = 0;
`ifdef GRAD_SEQ_LOOP_EN
            lp = $urandom_range(0, 1) == 1;
            if (lp && ns > 0) sv = ns + 2;
`endif
            ivf = iv < 8 ? 8 : iv;
            run(ns, iv, md, lp, sv, sd, 12 + (ns + 3) * (ivf + 36));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
